// File: rtl/fifo_drain_arbiter_if.sv
// Handshake bundle between the source FIFO bank, the drain arbiter and the destination FIFO bank.
interface fifo_drain_arbiter_if #(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned N_PORTS = 4
);
    logic [N_PORTS-1:0]        fifo_empty;
    logic [N_PORTS-1:0]        fifo_rd;
    logic [N_PORTS-1:0]        valid_in;
    logic [N_PORTS*DATA_W-1:0] data_in;
    logic [N_PORTS-1:0]        pause_in;
    logic [N_PORTS-1:0]        push;
    logic [DATA_W-1:0]         data_out;
    logic                      active;
    logic                      err;

    // Arbiter side
    modport master (
        input  fifo_empty, valid_in, data_in, pause_in,
        output fifo_rd, push, data_out, active, err
    );

    // FIFO-bank / environment side
    modport slave (
        output fifo_empty, valid_in, data_in, pause_in,
        input  fifo_rd, push, data_out, active, err
    );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of four source FIFOs into four destination FIFOs, routed by the word's
// two MSBs and held while the destination signals pause.
module fifo_drain_arbiter #(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned N_PORTS = 4
) (
    input logic                  clk,
    input logic                  RESET_L,
    fifo_drain_arbiter_if.master bus
);
    localparam int unsigned SEL_W = $clog2(N_PORTS);

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    state_e              r_state;
    logic [DATA_W-1:0]   r_hold;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_found;
    logic [SEL_W-1:0]    w_cand;
    logic [SEL_W-1:0]    w_idx;
    logic [SEL_W-1:0]    w_dest;
    logic [DATA_W-1:0]   w_sel_data;
    logic [N_PORTS-1:0]  w_rd;
    logic [N_PORTS-1:0]  w_push;
    logic                w_err;

    assign w_dest = r_hold[DATA_W-1 -: SEL_W];

    // First non-empty source after the last grant, wrapping modulo N_PORTS
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            w_idx = r_rr_ptr + SEL_W'(i);
            if (!w_found && !bus.fifo_empty[w_idx]) begin
                w_found = 1'b1;
                w_cand  = w_idx;
            end
        end
    end

    // Select the read data lane of the source popped last cycle
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_data = bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pop/push/error strobes decoded from the current state
    always_comb begin
        w_rd   = '0;
        w_push = '0;
        w_err  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_found) w_rd[w_cand] = 1'b1;
            end
            StRead: begin
                if (!bus.valid_in[r_sel]) w_err = 1'b1;
            end
            StHold: begin
                // A new pop overlaps the push so a word can move every two cycles
                if (!bus.pause_in[w_dest]) begin
                    w_push[w_dest] = 1'b1;
                    if (w_found) w_rd[w_cand] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Strobes are forced low for the whole time reset is held, not just after the edge
    assign bus.fifo_rd  = RESET_L ? w_rd   : '0;
    assign bus.push     = RESET_L ? w_push : '0;
    assign bus.err      = RESET_L & w_err;
    assign bus.data_out = r_hold;
    assign bus.active   = (r_state != StIdle);

    // FSM: grant, capture the popped word, then release it to its destination
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state  <= StIdle;
            r_hold   <= '0;
            r_sel    <= '0;
            r_rr_ptr <= SEL_W'(N_PORTS - 1);
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_sel    <= w_cand;
                        r_rr_ptr <= w_cand;
                        r_state  <= StRead;
                    end
                end
                StRead: begin
                    if (bus.valid_in[r_sel]) begin
                        r_hold  <= w_sel_data;
                        r_state <= StHold;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StHold: begin
                    if (!bus.pause_in[w_dest]) begin
                        if (w_found) begin
                            r_sel    <= w_cand;
                            r_rr_ptr <= w_cand;
                            r_state  <= StRead;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
